debug_trace_uart: RTL and testbench

Consumes the six 32-bit debug words the core exports (`chip_debug_out0`..`chip_debug_out5`: PC, address, instruction, etc.). Each `capture` pulse (typically tied to the core's `step`) snapshots all six words and streams them as one ASCII hex line over a UART 8N1 transmitter, for board-level single-step tracing. Sits directly downstream of the core's debug outputs, on the same clock.

---
 rtl/debug_trace_uart.sv | 162 ++++++++++++++++
 tb/tb_debug_trace_uart.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_uart.sv
// Snapshots six 32-bit debug words on capture and streams them as one
// 55-character uppercase-hex ASCII line over a UART 8N1 transmitter.
module debug_trace_uart #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] dbg0,
  input  logic [31:0] dbg1,
  input  logic [31:0] dbg2,
  input  logic [31:0] dbg3,
  input  logic [31:0] dbg4,
  input  logic [31:0] dbg5,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dropped
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FIN} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [5:0]    char_idx;
  logic [7:0]    shift;
  logic [31:0]   shadow [6];

  logic [5:0]    nxt_idx;
  logic [5:0]    word;
  logic [5:0]    pos;
  logic [31:0]   sel_word;
  logic [3:0]    nib;
  logic [7:0]    nxt_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character that follows the one currently on the wire: 9 chars per word
  // (8 nibbles + separator), CR in word 5's separator slot, LF last.
  always_comb begin
    nxt_idx  = char_idx + 6'd1;
    word     = nxt_idx / 6'd9;
    pos      = nxt_idx % 6'd9;
    sel_word = '0;
    nib      = '0;
    case (word)
      6'd0:    sel_word = shadow[0];
      6'd1:    sel_word = shadow[1];
      6'd2:    sel_word = shadow[2];
      6'd3:    sel_word = shadow[3];
      6'd4:    sel_word = shadow[4];
      6'd5:    sel_word = shadow[5];
      default: sel_word = '0;
    endcase
    case (pos[2:0])
      3'd0:    nib = sel_word[31:28];
      3'd1:    nib = sel_word[27:24];
      3'd2:    nib = sel_word[23:20];
      3'd3:    nib = sel_word[19:16];
      3'd4:    nib = sel_word[15:12];
      3'd5:    nib = sel_word[11:8];
      3'd6:    nib = sel_word[7:4];
      default: nib = sel_word[3:0];
    endcase
    if (nxt_idx == 6'd54)
      nxt_char = 8'h0A;
    else if (pos == 6'd8)
      nxt_char = (word == 6'd5) ? 8'h0D : 8'h20;
    else
      nxt_char = hex_ascii(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dropped  <= '0;
      timer    <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      shift    <= '0;
    end else begin
      if (capture && busy && dropped != 8'hFF)
        dropped <= dropped + 8'd1;
      case (state)
        IDLE: begin
          if (capture) begin
            shadow[0] <= dbg0;
            shadow[1] <= dbg1;
            shadow[2] <= dbg2;
            shadow[3] <= dbg3;
            shadow[4] <= dbg4;
            shadow[5] <= dbg5;
            // Shadow is not yet valid this edge, so char 0 comes from dbg0 directly.
            shift     <= hex_ascii(dbg0[31:28]);
            tx        <= 1'b0;
            busy      <= 1'b1;
            timer     <= '0;
            char_idx  <= '0;
            state     <= START;
          end
        end
        START: begin
          if (timer == TLAST) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == TLAST) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == TLAST) begin
            timer <= '0;
            if (char_idx == 6'd54) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              char_idx <= nxt_idx;
              shift    <= nxt_char;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_trace_uart.sv
// Scoreboarded bench for debug_trace_uart: stimulus queues expected ASCII
// bytes, a UART receiver monitor decodes tx and compares against the queue.
module tb_debug_trace_uart;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture = 1'b0;
  logic [31:0] dbg0 = '0, dbg1 = '0, dbg2 = '0, dbg3 = '0, dbg4 = '0, dbg5 = '0;
  logic        tx, busy, done;
  logic [7:0]  dropped;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  logic [7:0] exp_q [$];

  debug_trace_uart #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .capture(capture),
    .dbg0(dbg0), .dbg1(dbg1), .dbg2(dbg2), .dbg3(dbg3), .dbg4(dbg4), .dbg5(dbg5),
    .tx(tx), .busy(busy), .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART receiver: offset counts cycles from the first start-bit cycle.
  int rx_off = -1;
  logic [7:0] rx_byte = '0;
  logic [7:0] rx_exp;
  always @(negedge clk) begin
    if (rst) begin
      rx_off = -1;
    end else if (rx_off < 0) begin
      if (tx === 1'b0) rx_off = 0;
    end else begin
      rx_off++;
      for (int i = 0; i < 8; i++)
        if (rx_off == D * (i + 1) + D / 2) rx_byte[i] = tx;
      if (rx_off == D * 9 + D / 2) begin
        chk("stop_bit", {31'b0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no char", rx_byte);
        end else begin
          rx_exp = exp_q.pop_front();
          chk("rx_char", {24'b0, rx_byte}, {24'b0, rx_exp});
        end
        rx_off = -1;
      end
    end
  end

  // mode: 0 plain, 1 first-char bit timing, 2 three drops, 3 300 drops, 4 snapshot
  task automatic run_frame(input string line, input int mode, input int rst_at);
    logic [9:0] pat;
    bit got_done;
    pat = 10'b0011000101;
    push_line(line);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("start_tx", {31'b0, tx}, 32'd0);
    chk("start_busy", {31'b0, busy}, 32'd1);
    if (mode == 4) dbg2 = 32'hFFFF_FFFF;
    got_done = 0;
    for (int k = 1; k <= 2300 && !got_done; k++) begin
      if (mode == 2) capture = (k == 100 || k == 500 || k == 900);
      if (mode == 3) capture = (k >= 10 && k < 310);
      if (k == rst_at) rst = 1'b1;
      tick();
      if (k == rst_at) begin
        rst = 1'b0;
        capture = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dropped", {24'b0, dropped}, 32'd0);
        tick();
        return;
      end
      if (mode == 1 && k < 40) chk("bit_slot", {31'b0, tx}, {31'b0, pat[9 - k / D]});
      if (done === 1'b1) begin
        got_done = 1;
        chk("done_latency", k, 2200);
        chk("done_busy", {31'b0, busy}, 32'd1);
      end
    end
    capture = 1'b0;
    chk("done_seen", {31'b0, got_done}, 32'd1);
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("queue_drained", exp_q.size(), 0);
    if (mode == 2) exp_drop = (exp_drop + 3 > 255) ? 255 : exp_drop + 3;
    if (mode == 3) exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    chk("dropped", {24'b0, dropped}, exp_drop);
  endtask

  initial begin : stim
    string l1, l2;
    bit got_done;
    l1 = "1234ABCD 00000000 00000000 00000000 00000000 00000000";
    repeat (3) tick();
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_dropped", {24'b0, dropped}, 32'd0);
    rst = 1'b0;
    tick();

    dbg0 = 32'h1234_ABCD;
    run_frame(l1, 0, -1);

    dbg0 = 32'hF000_0000;
    run_frame("F0000000 00000000 00000000 00000000 00000000 00000000", 1, -1);

    dbg0 = 32'h1234_ABCD;
    run_frame(l1, 2, -1);
    run_frame(l1, 3, -1);

    // rst and capture together: reset wins, no frame starts
    rst = 1'b1;
    capture = 1'b1;
    tick();
    rst = 1'b0;
    capture = 1'b0;
    exp_drop = 0;
    chk("rstcap_tx", {31'b0, tx}, 32'd1);
    chk("rstcap_busy", {31'b0, busy}, 32'd0);
    chk("rstcap_dropped", {24'b0, dropped}, 32'd0);
    tick();
    chk("rstcap_no_frame", {31'b0, busy}, 32'd0);

    dbg0 = 32'h0;
    dbg2 = 32'h0000_0013;
    run_frame("00000000 00000000 00000013 00000000 00000000 00000000", 4, -1);

    // back-to-back with capture held high
    dbg0 = 32'h1234_ABCD;
    dbg2 = 32'h0;
    push_line(l1);
    push_line(l1);
    capture = 1'b1;
    tick();
    chk("b2b_start1", {31'b0, tx}, 32'd0);
    got_done = 0;
    for (int k = 1; k <= 2300 && !got_done; k++) begin
      tick();
      if (done === 1'b1) begin
        got_done = 1;
        chk("b2b_done1", k, 2200);
      end
    end
    chk("b2b_done1_seen", {31'b0, got_done}, 32'd1);
    tick();
    chk("b2b_idle", {31'b0, busy}, 32'd0);
    tick();
    capture = 1'b0;
    chk("b2b_start2_tx", {31'b0, tx}, 32'd0);
    chk("b2b_start2_busy", {31'b0, busy}, 32'd1);
    got_done = 0;
    for (int k = 1; k <= 2300 && !got_done; k++) begin
      tick();
      if (done === 1'b1) begin
        got_done = 1;
        chk("b2b_done2", k, 2200);
      end
    end
    chk("b2b_done2_seen", {31'b0, got_done}, 32'd1);
    tick();
    chk("b2b_queue", exp_q.size(), 0);
    exp_drop = 255;
    chk("b2b_dropped", {24'b0, dropped}, exp_drop);

    // reset during the 10th character's data bits, with one drop beforehand
    dbg0 = 32'hDEAD_BEEF;
    dbg5 = 32'h0000_00A5;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_drop = 0;
    tick();
    run_frame("DEADBEEF 00000000 00000000 00000000 00000000 000000A5", 2, 9 * 10 * D + 10);
    dbg1 = 32'h8000_0001;
    run_frame("DEADBEEF 80000001 00000000 00000000 00000000 000000A5", 0, -1);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
